// File: rtl/freq_step_ctrl.sv
// freq_step_ctrl: debounced +/- buttons driving a saturating phase-step word.
// Define AUTOREPEAT_EN for hold-to-repeat (IDLE/DELAY/REPEAT); otherwise one step per press (IDLE/HELD).
module freq_step_ctrl #(
   parameter int STEP_W          = 8,
   parameter int STEP_MIN        = 1,
   parameter int STEP_MAX        = 255,
   parameter int STEP_INIT       = 16,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              Bt_Plus,
   input  logic              Bt_Minus,
   output logic [STEP_W-1:0] Step,
   output logic              Step_Valid,
   output logic              At_Limit
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [STEP_W:0] MIN_X = (STEP_W+1)'(STEP_MIN);
   localparam logic [STEP_W:0] MAX_X = (STEP_W+1)'(STEP_MAX);

   if (STEP_MIN < 1 || STEP_MAX > 2**STEP_W - 1 || STEP_MIN > STEP_MAX || STEP_INIT < STEP_MIN ||
       STEP_INIT > STEP_MAX || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("freq_step_ctrl: illegal parameter set");
   end

`ifdef AUTOREPEAT_EN
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   localparam int TM_W = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   logic [TM_W-1:0] tmr_q, tmr_d;
`else
   typedef enum logic {IDLE, HELD} state_t;
`endif

   state_t            state_q, state_d;
   logic [1:0]        sync1_q, sync2_q, db_q, db_d;
   logic [DB_W-1:0]   cnt_q [2];
   logic [DB_W-1:0]   cnt_d [2];
   logic [STEP_W-1:0] step_q, step_d;
   logic [STEP_W:0]   inc_x, dec_x, nxt_x;
   logic              valid_q, valid_d, dir_q, dir_d, apply, cmd_up, cmd_dn, act;

   // index 0 = Plus, 1 = Minus
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : db_q[i];
         cnt_d[i] = (sync2_q[i] != db_q[i] && cnt_q[i] != DB_W'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + DB_W'(1) : '0;
      end
   end

   assign cmd_up = db_q[0] & ~db_q[1];
   assign cmd_dn = db_q[1] & ~db_q[0];
   assign act    = dir_q ? cmd_up : cmd_dn;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      apply   = 1'b0;
`ifdef AUTOREPEAT_EN
      tmr_d   = (state_q == IDLE) ? '0 : tmr_q + TM_W'(1);
`endif
      case (state_q)
         IDLE: if (cmd_up | cmd_dn) begin
            apply   = 1'b1;
            dir_d   = cmd_up;
`ifdef AUTOREPEAT_EN
            state_d = DELAY;
`else
            state_d = HELD;
`endif
         end
`ifdef AUTOREPEAT_EN
         DELAY: if (!act) state_d = IDLE;
         else if (tmr_q == TM_W'(REPEAT_DELAY - 1)) begin
            apply   = 1'b1;
            tmr_d   = '0;
            state_d = REPEAT;
         end
         REPEAT: if (!act) state_d = IDLE;
         else if (tmr_q == TM_W'(REPEAT_RATE - 1)) begin
            apply = 1'b1;
            tmr_d = '0;
         end
`else
         HELD: if (!act) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // one spare bit keeps both saturation checks free of wrap-around
   assign inc_x   = {1'b0, step_q} + (STEP_W+1)'(1);
   assign dec_x   = {1'b0, step_q} - (STEP_W+1)'(1);
   assign nxt_x   = dir_d ? ((inc_x > MAX_X) ? MAX_X : inc_x)
                          : ((dec_x[STEP_W] || dec_x < MIN_X) ? MIN_X : dec_x);
   assign step_d  = apply ? nxt_x[STEP_W-1:0] : step_q;
   assign valid_d = apply && (nxt_x[STEP_W-1:0] != step_q);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         cnt_q   <= '{default: '0};
         state_q <= IDLE;
         dir_q   <= 1'b0;
         step_q  <= STEP_W'(STEP_INIT);
         valid_q <= 1'b0;
`ifdef AUTOREPEAT_EN
         tmr_q   <= '0;
`endif
      end else begin
         sync1_q <= {Bt_Minus, Bt_Plus};
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         valid_q <= valid_d;
`ifdef AUTOREPEAT_EN
         tmr_q   <= tmr_d;
`endif
      end
   end

   assign Step       = step_q;
   assign Step_Valid = valid_q;
   assign At_Limit   = (step_q == STEP_W'(STEP_MIN)) || (step_q == STEP_W'(STEP_MAX));
endmodule
